// File: rtl/status_input_pio.sv
// Avalon-MM status input PIO: synchronizes in_port, captures selected edges into a
// sticky W1C register; optional level IRQ when STATUS_PIO_IRQ_EN is defined.
module status_input_pio #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port
`ifdef STATUS_PIO_IRQ_EN
    ,
    output logic             irq
`endif
);

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_RSVD    = 2'd1,
        REG_IRQMASK = 2'd2,
        REG_EDGECAP = 2'd3
    } reg_e;

    localparam int unsigned          CNT_W   = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]     ARM_MAX = CNT_W'(SYNC_STAGES);

    reg_e             reg_sel;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] cap_q;
    logic [CNT_W-1:0] arm_cnt;
    logic             armed_q;
    logic             rd_en;
    logic             wr_en;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    assign reg_sel      = reg_e'(address);
    assign rd_en        = chipselect & ~read_n;
    assign wr_en        = chipselect & ~write_n;
    assign sync         = sync_q[SYNC_STAGES-1];
    // writedata bits at and above WIDTH are dropped on every register
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync;
        end
    end

    // armed_q lags the saturated counter by one cycle so prev_q already holds a
    // real sample when edges are first accepted; inputs held high never look like a rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt <= '0;
            armed_q <= 1'b0;
        end else begin
            if (arm_cnt != ARM_MAX) arm_cnt <= arm_cnt + 1'b1;
            armed_q <= (arm_cnt == ARM_MAX);
        end
    end

    always_comb begin
        rise = sync & ~prev_q;
        fall = ~sync & prev_q;
        case (EDGE_TYPE)
            0:       evt = rise;
            1:       evt = fall;
            default: evt = rise | fall;
        endcase
        if (!armed_q) evt = '0;
    end

    always_comb begin
        clr = '0;
        if (wr_en && reg_sel == REG_EDGECAP) clr = writedata[WIDTH-1:0];
    end

    // set has priority over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cap_q <= '0;
        else       cap_q <= (cap_q & ~clr) | evt;
    end

`ifdef STATUS_PIO_IRQ_EN
    logic [WIDTH-1:0] mask_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && reg_sel == REG_IRQMASK) mask_q <= writedata[WIDTH-1:0];
            irq <= |(cap_q & mask_q);
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_DATA:    rd_word[WIDTH-1:0] = sync;
            REG_EDGECAP: rd_word[WIDTH-1:0] = cap_q;
`ifdef STATUS_PIO_IRQ_EN
            REG_IRQMASK: rd_word[WIDTH-1:0] = mask_q;
`endif
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      readdata <= '0;
        else if (rd_en) readdata <= rd_word;
    end

endmodule

// File: tb/tb_status_input_pio.sv
// Bench for status_input_pio (WIDTH=4, SYNC_STAGES=2, rising edge); reads are scored
// through a queue of expected values popped one cycle after each read strobe.
`timescale 1ns/1ps
module tb_status_input_pio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [3:0]  in_port = 4'hF;
`ifdef STATUS_PIO_IRQ_EN
    logic        irq;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [3:0]  in_val;
        bit          do_wr;
        logic [1:0]  wr_addr;
        logic [31:0] wdata;
        logic [1:0]  rd_addr;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[13];

    logic rd_pend;

    always #5 clk = ~clk;

    status_input_pio #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .EDGE_TYPE(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .read_n(read_n),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port)
`ifdef STATUS_PIO_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) rd_pend <= 1'b0;
        else       rd_pend <= chipselect & ~read_n;
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check(e.name, readdata, e.exp);
            end
        end
    end

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_all();
        in_port = 4'h0;
        idle(5);
        bus_write(2'd3, 32'hF);
    endtask

    initial begin
        logic [31:0] mask_rb;
`ifdef STATUS_PIO_IRQ_EN
        mask_rb = 32'h3;
`else
        mask_rb = 32'h0;
`endif
        vecs[0]  = '{4'h0, 1'b0, 2'd0, 32'h0,        2'd0, 32'h0,   "v0_fall_data"};
        vecs[1]  = '{4'h0, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0,   "v1_fall_ignored"};
        vecs[2]  = '{4'h5, 1'b0, 2'd0, 32'h0,        2'd3, 32'h5,   "v2_rise_5"};
        vecs[3]  = '{4'h5, 1'b1, 2'd3, 32'h1,        2'd3, 32'h4,   "v3_w1c_bit0"};
        vecs[4]  = '{4'h5, 1'b1, 2'd0, 32'hFFFF,     2'd0, 32'h5,   "v4_data_ro"};
        vecs[5]  = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd3, 32'hE,   "v5_rise_sticky"};
        vecs[6]  = '{4'hF, 1'b1, 2'd3, 32'hFFFFFFF0, 2'd3, 32'hE,   "v6_upper_wr_ign"};
        vecs[7]  = '{4'hF, 1'b1, 2'd3, 32'hF,        2'd3, 32'h0,   "v7_clear_all"};
        vecs[8]  = '{4'h0, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0,   "v8_fall_ignored"};
        vecs[9]  = '{4'hF, 1'b1, 2'd1, 32'hF,        2'd1, 32'h0,   "v9_rsvd_zero"};
        vecs[10] = '{4'hF, 1'b1, 2'd2, 32'h3,        2'd2, mask_rb, "v10_irqmask"};
        vecs[11] = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd3, 32'hF,   "v11_cap_all"};
        vecs[12] = '{4'hF, 1'b1, 2'd3, 32'hF,        2'd3, 32'h0,   "v12_clear_all"};

        // reset held with inputs high: nothing may be captured after release
        idle(3);
        check("rst_readdata", readdata, 32'h0);
`ifdef STATUS_PIO_IRQ_EN
        check("rst_irq", {31'b0, irq}, 32'h0);
`endif
        reset = 1'b0;
        idle(10);
        bus_read(2'd3, 32'h0, "t1_no_false_cap");
        bus_read(2'd0, 32'hF, "t1_data");
        idle(1);

        foreach (vecs[i]) begin
            in_port = vecs[i].in_val;
            idle(5);
            if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].wdata);
            bus_read(vecs[i].rd_addr, vecs[i].exp, vecs[i].name);
            idle(1);
        end

        // edge latency: capture lands on the third clk edge after the change
        in_port = 4'h0;
        idle(5);
        in_port = 4'h5;
        idle(2);
        bus_read(2'd3, 32'h0, "t2_lat_edge2");
        bus_read(2'd3, 32'h5, "t2_lat_edge3");
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, 32'h4, "t2_w1c");
        idle(1);

        // same-cycle set and clear on bit0
        clear_all();
        in_port = 4'h1;
        idle(2);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, 32'h1, "t3_set_wins");
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, 32'h0, "t3_clr_after");
        idle(1);

`ifdef STATUS_PIO_IRQ_EN
        clear_all();
        bus_write(2'd2, 32'h2);
        in_port = 4'h1;
        idle(5);
        check("t4_irq_masked", {31'b0, irq}, 32'h0);
        bus_read(2'd3, 32'h1, "t4_cap_bit0");
        in_port = 4'h3;
        idle(3);
        check("t4_irq_at_cap", {31'b0, irq}, 32'h0);
        idle(1);
        check("t4_irq_set", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h2);
        check("t4_irq_hold", {31'b0, irq}, 32'h1);
        idle(1);
        check("t4_irq_clr", {31'b0, irq}, 32'h0);
`endif

        // back-to-back reads of every address
        clear_all();
        bus_write(2'd2, 32'hC);
        in_port = 4'h9;
        idle(5);
        bus_read(2'd0, 32'h9, "t5_rd_data");
        bus_read(2'd1, 32'h0, "t5_rd_rsvd");
        bus_read(2'd2, (mask_rb != 0) ? 32'hC : 32'h0, "t5_rd_mask");
        bus_read(2'd3, 32'h9, "t5_rd_cap");
        idle(1);

        // asynchronous reset mid-stream
        clear_all();
        bus_write(2'd2, 32'h2);
        in_port = 4'hA;
        idle(5);
        bus_read(2'd3, 32'hA, "t6_pre_cap");
        idle(1);
`ifdef STATUS_PIO_IRQ_EN
        check("t6_pre_irq", {31'b0, irq}, 32'h1);
`endif
        #2 reset = 1'b1;
        #1 check("t6_rst_readdata", readdata, 32'h0);
`ifdef STATUS_PIO_IRQ_EN
        check("t6_rst_irq", {31'b0, irq}, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        idle(10);
        bus_read(2'd3, 32'h0, "t6_no_false_cap");
        bus_read(2'd2, 32'h0, "t6_mask_cleared");
        bus_read(2'd0, 32'hA, "t6_data");
        clear_all();
        in_port = 4'hA;
        idle(5);
        bus_read(2'd3, 32'hA, "t6_rearmed");
        idle(2);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
